// File: rtl/adder_seq_pkg.sv
// Shared definitions for the add-datapath sequencing controller:
// state codes, the A-source select values and the FSM state type.
package adder_seq_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CAP_A  = 3'd1;
    localparam logic [2:0] ST_WAIT_B = 3'd2;
    localparam logic [2:0] ST_CAP_B  = 3'd3;
    localparam logic [2:0] ST_ADD    = 3'd4;
    localparam logic [2:0] ST_SHOW   = 3'd5;

    localparam logic SEL_A_DATA = 1'b0;
    localparam logic SEL_A_SUM  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_CAP_A  = ST_CAP_A,
        S_WAIT_B = ST_WAIT_B,
        S_CAP_B  = ST_CAP_B,
        S_ADD    = ST_ADD,
        S_SHOW   = ST_SHOW
    } state_t;

endpackage

// File: rtl/adder_seq_ctrl_step_edge_det.sv
// Rising-edge detector for the operator step button.
// Optional feature macro: ADDER_SEQ_STEP_SYNC_EN inserts a two-flop
// synchronizer ahead of the detector. Every flop resets to 1 so that a
// button already held down when reset releases never produces an edge.
module step_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic step_i,
    output logic edge_o
);

    logic stepSync;
    logic step_q;

`ifdef ADDER_SEQ_STEP_SYNC_EN
    logic syncFirst_q;
    logic syncSecond_q;

    // Two-stage synchronizer bringing the asynchronous button into the clock domain
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            syncFirst_q  <= 1'b1;
            syncSecond_q <= 1'b1;
        end else begin
            syncFirst_q  <= step_i;
            syncSecond_q <= syncFirst_q;
        end
    end

    assign stepSync = syncSecond_q;
`else
    assign stepSync = step_i;
`endif

    // Previous-cycle copy of the (synchronized) button level for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            step_q <= 1'b1;
        end else begin
            step_q <= stepSync;
        end
    end

    assign edge_o = stepSync & ~step_q;

endmodule

// File: rtl/adder_seq_ctrl.sv
// Sequencing controller for the 8-bit add datapath. One step button walks
// through capture of A, capture of B and the add, producing one-cycle load
// enables. An accumulate mode feeds S back into A for chained additions,
// with sticky overflow across the chain and a saturating add counter.
// Optional feature macro: ADDER_SEQ_STEP_SYNC_EN (button synchronizer,
// handled inside step_edge_det).
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             step,
    input  logic             acc_mode,
    input  logic             ovf_in,
    output logic             ld_a,
    output logic             ld_b,
    output logic             ld_s,
    output logic             sel_a,
    output logic             busy,
    output logic             done,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] op_count,
    output logic [2:0]       state
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    logic             accChain_q;
    logic             ovfSticky_q;
    logic [CNT_W-1:0] opCount_q;
    logic [CNT_W-1:0] opCount_d;
    logic             stepEdge;

    step_edge_det u_step_edge_det (
        .clk_i  (CLK),
        .rst_i  (RST),
        .step_i (step),
        .edge_o (stepEdge)
    );

    // Saturating next value of the completed-addition counter
    always_comb begin
        opCount_d = opCount_q;
        if (opCount_q != CNT_MAX) begin
            opCount_d = opCount_q + CNT_W'(1);
        end
    end

    // Sequencer: state walk plus the chain mode, sticky overflow and counter registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            accChain_q  <= SEL_A_DATA;
            ovfSticky_q <= 1'b0;
            opCount_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (stepEdge) begin
                        state_q    <= S_CAP_A;
                        accChain_q <= SEL_A_DATA;
                    end
                end
                S_CAP_A: begin
                    state_q <= S_WAIT_B;
                end
                S_WAIT_B: begin
                    if (stepEdge) begin
                        state_q <= S_CAP_B;
                    end
                end
                S_CAP_B: begin
                    state_q <= S_ADD;
                end
                S_ADD: begin
                    state_q     <= S_SHOW;
                    opCount_q   <= opCount_d;
                    ovfSticky_q <= accChain_q ? (ovfSticky_q | ovf_in) : ovf_in;
                end
                S_SHOW: begin
                    if (stepEdge) begin
                        state_q    <= S_CAP_A;
                        accChain_q <= acc_mode;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Moore decode of the enables and status flags from the state register
    always_comb begin
        ld_a = 1'b0;
        ld_b = 1'b0;
        ld_s = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_CAP_A: begin
                ld_a = 1'b1;
                busy = 1'b1;
            end
            S_CAP_B: begin
                ld_b = 1'b1;
                busy = 1'b1;
            end
            S_ADD: begin
                ld_s = 1'b1;
                busy = 1'b1;
            end
            S_SHOW: begin
                done = 1'b1;
            end
            default: begin
                ld_a = 1'b0;
            end
        endcase
    end

    assign sel_a      = accChain_q;
    assign ovf_sticky = ovfSticky_q;
    assign op_count   = opCount_q;
    assign state      = state_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl: an ideal A/B/S datapath driven by
// the DUT enables, a transaction-level expectation model and a per-cycle
// compare process, followed by directed scenarios and a random run.
module tb_adder_seq_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [2:0] C_IDLE  = 3'd0;
    localparam logic [2:0] C_CAPA  = 3'd1;
    localparam logic [2:0] C_WAITB = 3'd2;
    localparam logic [2:0] C_CAPB  = 3'd3;
    localparam logic [2:0] C_ADD   = 3'd4;
    localparam logic [2:0] C_SHOW  = 3'd5;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             step = 1'b0;
    logic             acc_mode = 1'b0;
    logic             ovf_in;
    logic             ld_a, ld_b, ld_s, sel_a, busy, done, ovf_sticky;
    logic [CNT_W-1:0] op_count;
    logic [2:0]       state;

    logic [7:0] swData = 8'h00;
    logic [7:0] regA = 8'h00;
    logic [7:0] regB = 8'h00;
    logic [7:0] regS = 8'h00;
    logic [7:0] sumAB;

    int testsRun = 0;
    int testsFailed = 0;

    adder_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .step       (step),
        .acc_mode   (acc_mode),
        .ovf_in     (ovf_in),
        .ld_a       (ld_a),
        .ld_b       (ld_b),
        .ld_s       (ld_s),
        .sel_a      (sel_a),
        .busy       (busy),
        .done       (done),
        .ovf_sticky (ovf_sticky),
        .op_count   (op_count),
        .state      (state)
    );

    always #5 CLK = ~CLK;

    function automatic logic addOvf(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] s;
        s = a + b;
        return (a[7] == b[7]) && (s[7] != a[7]);
    endfunction

    // Ideal datapath reacting to whatever enables the DUT produces
    always_ff @(posedge CLK) begin
        if (ld_a) regA <= sel_a ? regS : swData;
        if (ld_b) regB <= swData;
        if (ld_s) regS <= sumAB;
    end

    assign sumAB  = regA + regB;
    assign ovf_in = addOvf(regA, regB);

    // Expectation model: which state comes next, what the chain has computed
    logic [2:0] mState = C_IDLE;
    logic [2:0] upcoming[$];
    logic       mAcc = 1'b0;
    logic       mOvf = 1'b0;
    int         mCount = 0;
    logic       mPrev = 1'b1;
    logic       mSync1 = 1'b1;
    logic       mSync2 = 1'b1;
    logic [7:0] mA = 8'h00;
    logic [7:0] mB = 8'h00;
    logic [7:0] mS = 8'h00;
    logic       stepSeen;
    logic       edgeSeen;

    initial begin
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) begin
                mState = C_IDLE;
                upcoming.delete();
                mAcc   = 1'b0;
                mOvf   = 1'b0;
                mCount = 0;
                mPrev  = 1'b1;
                mSync1 = 1'b1;
                mSync2 = 1'b1;
            end else begin
`ifdef ADDER_SEQ_STEP_SYNC_EN
                stepSeen = mSync2;
                mSync2   = mSync1;
                mSync1   = step;
`else
                stepSeen = step;
`endif
                edgeSeen = stepSeen && !mPrev;
                mPrev    = stepSeen;
                if (mState == C_CAPA) mA = mAcc ? mS : swData;
                if (mState == C_CAPB) mB = swData;
                if (mState == C_ADD) begin
                    mOvf = mAcc ? (mOvf | addOvf(mA, mB)) : addOvf(mA, mB);
                    mS   = mA + mB;
                    if (mCount < CNT_MAX) mCount++;
                end
                if (upcoming.size() > 0) begin
                    mState = upcoming.pop_front();
                end else if (edgeSeen) begin
                    if (mState == C_IDLE || mState == C_SHOW) begin
                        mAcc = (mState == C_SHOW) ? acc_mode : 1'b0;
                        mState = C_CAPA;
                        upcoming.push_back(C_WAITB);
                    end else if (mState == C_WAITB) begin
                        mState = C_CAPB;
                        upcoming.push_back(C_ADD);
                        upcoming.push_back(C_SHOW);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model
    initial begin
        forever begin
            @(negedge CLK);
            checkOutput("state", state, mState);
            checkOutput("ld_a", ld_a, mState == C_CAPA);
            checkOutput("ld_b", ld_b, mState == C_CAPB);
            checkOutput("ld_s", ld_s, mState == C_ADD);
            checkOutput("busy", busy, mState == C_CAPA || mState == C_CAPB || mState == C_ADD);
            checkOutput("done", done, mState == C_SHOW);
            checkOutput("sel_a", sel_a, mAcc);
            checkOutput("ovf_sticky", ovf_sticky, mOvf);
            checkOutput("op_count", op_count, mCount);
            checkOutput("sumReg", regS, mS);
            checkOutput("onehotLd", int'($countones({ld_a, ld_b, ld_s}) <= 1), 1);
        end
    end

    // One button press with switch data held until the load has happened
    task automatic applyStimulus(input logic [7:0] data, input logic acc);
        swData   = data;
        acc_mode = acc;
        step     = 1'b1;
        @(negedge CLK);
        step = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        checkOutput("resetState", state, 0);
        checkOutput("resetCount", op_count, 0);
        @(negedge CLK);

        // Basic chain 0x05 + 0x03
        applyStimulus(8'h05, 1'b0);
        applyStimulus(8'h03, 1'b0);
        checkOutput("firstShow", state, 5);
        checkOutput("firstDone", done, 1);
        checkOutput("firstSum", regS, 8'h08);
        checkOutput("firstCount", op_count, 1);
        checkOutput("firstOvf", ovf_sticky, 0);

        // Overflowing chain, then a clean non-accumulate chain clears it
        applyStimulus(8'h50, 1'b0);
        applyStimulus(8'h40, 1'b0);
        checkOutput("ovfSet", ovf_sticky, 1);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h02, 1'b0);
        checkOutput("ovfCleared", ovf_sticky, 0);

        // Accumulate chain 0x30+0x30, +0x30 (overflow), +0x00 (sticky holds)
        applyStimulus(8'h30, 1'b0);
        applyStimulus(8'h30, 1'b0);
        checkOutput("accBase", regS, 8'h60);
        swData = 8'hAA;
        acc_mode = 1'b1;
        step = 1'b1;
        @(negedge CLK);
        checkOutput("selAcc", sel_a, 1);
        step = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        applyStimulus(8'h30, 1'b1);
        checkOutput("accOvf", ovf_sticky, 1);
        checkOutput("accSum", regS, 8'h90);
        applyStimulus(8'hAA, 1'b1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("accSticky", ovf_sticky, 1);
        checkOutput("accCount", op_count, 6);

        // Asynchronous reset in WAIT_B takes effect within the cycle
        applyStimulus(8'h11, 1'b1);
        checkOutput("preRstState", state, 2);
        #2 RST = 1'b1;
        #1;
        checkOutput("rstState", state, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstSel", sel_a, 0);
        checkOutput("rstOvf", ovf_sticky, 0);
        checkOutput("rstCount", op_count, 0);
        checkOutput("rstLd", {ld_a, ld_b, ld_s, done}, 0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Step toggled during CAP_B and ADD is ignored
        applyStimulus(8'h11, 1'b0);
        swData = 8'h22;
        step = 1'b1;
        @(negedge CLK);
        step = 1'b0;
        @(negedge CLK);
        step = 1'b1;
        @(negedge CLK);
        checkOutput("toggleShow", state, 5);
        step = 1'b0;
        @(negedge CLK);
        checkOutput("toggleHold", state, 5);

        // Button held high through reset release does not start a chain
        step = 1'b1;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        checkOutput("heldIdle", state, 0);
        step = 1'b0;
        @(negedge CLK);
        applyStimulus(8'h07, 1'b0);
        checkOutput("heldThenPress", state, 2);

        // Random stimulus, long enough to drive the counter into saturation
        for (int i = 0; i < 800; i++) begin
            step     = ($urandom_range(0, 2) == 0);
            acc_mode = $urandom_range(0, 1);
            swData   = 8'($urandom);
            @(negedge CLK);
        end
        step = 1'b0;
        repeat (4) @(negedge CLK);
        checkOutput("satCount", op_count, CNT_MAX);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
